// File: rtl/sweep_collector_pkg.sv
// Shared types and constants for the sweep result collector.
// State encoding and status word layout are visible on the bus.
package sweep_collector_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [1:0] BANK_MAG    = 2'b00;
  localparam logic [1:0] BANK_PHASE  = 2'b01;
  localparam logic [1:0] BANK_STATUS = 2'b10;

  localparam int ST_DONE     = 16;
  localparam int ST_ERR_ADDR = 17;
  localparam int ST_ERR_DUP  = 18;
  localparam int ST_ERR_IDLE = 19;
  localparam int ST_STATE    = 20;

endpackage

// File: rtl/result_bank_ram.sv
// Per-point result memory with registered read, a valid bitmap
// and a count of distinct points written since the last clear.
module result_bank_ram #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          zero,
  input  logic [AW-1:0] zaddr,
  input  logic          wr,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          rd,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  output logic [7:0]    count,
  output logic          dup
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] vld;

  assign dup = wr && vld[waddr];

  always_ff @(posedge clk) begin
    if (zero)
      mem[zaddr] <= '0;
    else if (wr)
      mem[waddr] <= wdata;
  end

  // Read-first: a same-cycle write lands after this sample.
  always_ff @(posedge clk) begin
    if (reset)
      rdata <= '0;
    else if (rd)
      rdata <= mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      vld   <= '0;
      count <= '0;
    end else if (wr && !vld[waddr]) begin
      vld[waddr] <= 1'b1;
      count      <= count + 8'd1;
    end
  end

endmodule

// File: rtl/sweep_result_collector.sv
// Captures magnitude/phase results per sweep point and serves
// them plus a status word on the sys register bus.
module sweep_result_collector
  import sweep_collector_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_POINTS = 225
) (
  input  logic                  clk125,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  VALID_M,
  input  logic [DATA_WIDTH-1:0] MODULO,
  input  logic [ADDR_WIDTH-1:0] address_mem2,
  input  logic                  VALID_P,
  input  logic [DATA_WIDTH-1:0] PHASE,
  input  logic [ADDR_WIDTH-1:0] address_mem3,
  input  logic                  ren_sys,
  input  logic [ADDR_WIDTH+1:0] address_rd_sys,
  output logic [DATA_WIDTH-1:0] data_read_sys,
  output logic                  rack_sys,
  output logic                  sweep_done,
  output logic                  done_irq
);

  localparam logic [ADDR_WIDTH:0] NP =
    (ADDR_WIDTH+1)'(NUM_POINTS);
  localparam logic [7:0] NP8 = 8'(NUM_POINTS);

  state_t                  state;
  logic                    start_q;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic                    err_addr;
  logic                    err_dup;
  logic                    err_idle;
  logic [1:0]              bank_q;
  logic [DATA_WIDTH-1:0]   status_q;
  logic [DATA_WIDTH-1:0]   status;
  logic [DATA_WIDTH-1:0]   rdata_m;
  logic [DATA_WIDTH-1:0]   rdata_p;
  logic [7:0]              count_m;
  logic [7:0]              count_p;
  logic                    dup_m;
  logic                    dup_p;

  logic                  start_edge;
  logic                  cap;
  logic                  in_m;
  logic                  in_p;
  logic                  wr_m;
  logic                  wr_p;
  logic                  clr_banks;
  logic                  zero;
  logic [1:0]            bank;
  logic [ADDR_WIDTH-1:0] ridx;

  assign start_edge = start && !start_q;
  assign cap        = (state == CAPTURE) && !start_edge;
  assign in_m       = {1'b0, address_mem2} < NP;
  assign in_p       = {1'b0, address_mem3} < NP;
  assign wr_m       = cap && VALID_M && in_m;
  assign wr_p       = cap && VALID_P && in_p;
  assign clr_banks  = start_edge;
  assign zero       = (state == CLEAR);
  assign bank       = address_rd_sys[ADDR_WIDTH+1:ADDR_WIDTH];
  assign ridx       = address_rd_sys[ADDR_WIDTH-1:0];

  result_bank_ram #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_mag (
    .clk   (clk125),
    .reset (reset),
    .clr   (clr_banks),
    .zero  (zero),
    .zaddr (clr_addr),
    .wr    (wr_m),
    .waddr (address_mem2),
    .wdata (MODULO),
    .rd    (ren_sys && bank == BANK_MAG),
    .raddr (ridx),
    .rdata (rdata_m),
    .count (count_m),
    .dup   (dup_m)
  );

  result_bank_ram #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_phase (
    .clk   (clk125),
    .reset (reset),
    .clr   (clr_banks),
    .zero  (zero),
    .zaddr (clr_addr),
    .wr    (wr_p),
    .waddr (address_mem3),
    .wdata (PHASE),
    .rd    (ren_sys && bank == BANK_PHASE),
    .raddr (ridx),
    .rdata (rdata_p),
    .count (count_p),
    .dup   (dup_p)
  );

  always_comb begin
    status                 = '0;
    status[7:0]            = count_p;
    status[15:8]           = count_m;
    status[ST_DONE]        = sweep_done;
    status[ST_ERR_ADDR]    = err_addr;
    status[ST_ERR_DUP]     = err_dup;
    status[ST_ERR_IDLE]    = err_idle;
    status[ST_STATE +: 3]  = {1'b0, state};
  end

  always_comb begin
    case (bank_q)
      BANK_MAG:    data_read_sys = rdata_m;
      BANK_PHASE:  data_read_sys = rdata_p;
      BANK_STATUS: data_read_sys = status_q;
      default:     data_read_sys = '0;
    endcase
  end

  always_ff @(posedge clk125) begin
    if (reset) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      clr_addr   <= '0;
      sweep_done <= 1'b0;
      done_irq   <= 1'b0;
      err_addr   <= 1'b0;
      err_dup    <= 1'b0;
      err_idle   <= 1'b0;
      rack_sys   <= 1'b0;
      bank_q     <= BANK_MAG;
      status_q   <= '0;
    end else begin
      start_q  <= start;
      done_irq <= 1'b0;
      rack_sys <= ren_sys;
      if (ren_sys) begin
        bank_q   <= bank;
        status_q <= status;
      end
      if (start_edge) begin
        state      <= CLEAR;
        clr_addr   <= '0;
        sweep_done <= 1'b0;
        err_addr   <= 1'b0;
        err_dup    <= 1'b0;
        err_idle   <= 1'b0;
      end else begin
        if ((VALID_M || VALID_P) && state != CAPTURE)
          err_idle <= 1'b1;
        if (cap && ((VALID_M && !in_m) || (VALID_P && !in_p)))
          err_addr <= 1'b1;
        if (dup_m || dup_p)
          err_dup <= 1'b1;
        case (state)
          CLEAR: begin
            clr_addr <= clr_addr + 1'b1;
            if (&clr_addr)
              state <= CAPTURE;
          end
          CAPTURE: begin
            if (count_m == NP8 && count_p == NP8) begin
              state      <= DONE;
              done_irq   <= 1'b1;
              sweep_done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sweep_result_collector.sv
// Directed-vector bench for sweep_result_collector.
// Expected values are hand-computed constants.
module tb_sweep_result_collector;

  logic        clk125 = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        VALID_M = 1'b0;
  logic [31:0] MODULO = '0;
  logic [7:0]  address_mem2 = '0;
  logic        VALID_P = 1'b0;
  logic [31:0] PHASE = '0;
  logic [7:0]  address_mem3 = '0;
  logic        ren_sys = 1'b0;
  logic [9:0]  address_rd_sys = '0;
  logic [31:0] data_read_sys;
  logic        rack_sys;
  logic        sweep_done;
  logic        done_irq;

  int checks = 0;
  int failures = 0;
  int irq_cnt = 0;
  int irq_base;

  sweep_result_collector dut (
    .clk125         (clk125),
    .reset          (reset),
    .start          (start),
    .VALID_M        (VALID_M),
    .MODULO         (MODULO),
    .address_mem2   (address_mem2),
    .VALID_P        (VALID_P),
    .PHASE          (PHASE),
    .address_mem3   (address_mem3),
    .ren_sys        (ren_sys),
    .address_rd_sys (address_rd_sys),
    .data_read_sys  (data_read_sys),
    .rack_sys       (rack_sys),
    .sweep_done     (sweep_done),
    .done_irq       (done_irq)
  );

  always #4 clk125 = ~clk125;

  always @(posedge clk125)
    if (done_irq) irq_cnt++;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk125);
    #1;
  endtask

  task automatic rd_chk(input string tag,
                        input logic [1:0] b,
                        input logic [7:0] i,
                        input logic [31:0] exp);
    ren_sys = 1'b1;
    address_rd_sys = {b, i};
    tick();
    ren_sys = 1'b0;
    check({tag, "_ack"}, {31'd0, rack_sys}, 32'd1);
    check(tag, data_read_sys, exp);
  endtask

  task automatic mp(input logic vm, input logic [7:0] am,
                    input logic [31:0] dm,
                    input logic vp, input logic [7:0] ap,
                    input logic [31:0] dp);
    VALID_M = vm; address_mem2 = am; MODULO = dm;
    VALID_P = vp; address_mem3 = ap; PHASE = dp;
    tick();
    VALID_M = 1'b0;
    VALID_P = 1'b0;
  endtask

  task automatic outs_zero(input string tag);
    check({tag, "_data"}, data_read_sys, 32'd0);
    check({tag, "_rack"}, {31'd0, rack_sys}, 32'd0);
    check({tag, "_done"}, {31'd0, sweep_done}, 32'd0);
    check({tag, "_irq"}, {31'd0, done_irq}, 32'd0);
  endtask

  initial begin
    repeat (3) tick();
    outs_zero("rst");
    reset = 1'b0;
    rd_chk("idle_status", 2'b10, 8'd0, 32'h0);

    // start edge, then CLEAR must span exactly 256 cycles
    start = 1'b1;
    tick();
    repeat (254) tick();
    rd_chk("clear_255", 2'b10, 8'd0, 32'h0010_0000);
    rd_chk("clear_256", 2'b10, 8'd0, 32'h0010_0000);
    rd_chk("capture_st", 2'b10, 8'd0, 32'h0020_0000);
    rd_chk("mag5", 2'b00, 8'd5, 32'h0);

    mp(1'b1, 8'd3, 32'h1234, 1'b0, 8'd0, 32'h0);
    rd_chk("mag3", 2'b00, 8'd3, 32'h1234);
    tick();
    check("rack_low", {31'd0, rack_sys}, 32'd0);
    check("data_hold", data_read_sys, 32'h1234);

    // same-cycle read and write of index 10
    ren_sys = 1'b1;
    address_rd_sys = {2'b00, 8'd10};
    mp(1'b1, 8'd10, 32'hAAAA, 1'b0, 8'd0, 32'h0);
    ren_sys = 1'b0;
    check("read_first", data_read_sys, 32'h0);
    rd_chk("mag10", 2'b00, 8'd10, 32'hAAAA);
    mp(1'b1, 8'd240, 32'h5, 1'b0, 8'd0, 32'h0);
    rd_chk("st_cm2", 2'b10, 8'd0, 32'h0022_0200);

    // restart with a coinciding strobe
    start = 1'b0;
    tick();
    start = 1'b1;
    mp(1'b1, 8'd20, 32'h55, 1'b0, 8'd0, 32'h0);
    rd_chk("restart_st", 2'b10, 8'd0, 32'h0010_0000);
    repeat (260) tick();
    rd_chk("clean_st", 2'b10, 8'd0, 32'h0020_0000);
    rd_chk("dropped", 2'b00, 8'd20, 32'h0);
    rd_chk("cleared3", 2'b00, 8'd3, 32'h0);

    irq_base = irq_cnt;
    for (int i = 0; i < 200; i++)
      mp(1'b1, 8'(i), 32'(i * 3 + 1), 1'b1, 8'(i), 32'(i * 5));
    mp(1'b0, 8'd0, 32'h0, 1'b1, 8'd230, 32'h777);
    rd_chk("ph230", 2'b01, 8'd230, 32'h0);
    mp(1'b0, 8'd0, 32'h0, 1'b1, 8'd7, -32'sd100);
    rd_chk("ph7", 2'b01, 8'd7, 32'hFFFF_FF9C);
    rd_chk("st_200", 2'b10, 8'd0, 32'h0026_C8C8);
    check("no_early_irq", 32'(irq_cnt - irq_base), 32'd0);
    for (int i = 200; i < 225; i++)
      mp(1'b1, 8'(i), 32'(i * 3 + 1), 1'b1, 8'(i), 32'(i * 5));
    repeat (5) tick();
    check("irq_once", 32'(irq_cnt - irq_base), 32'd1);
    check("sweep_done", {31'd0, sweep_done}, 32'd1);
    rd_chk("st_done", 2'b10, 8'd0, 32'h0037_E1E1);
    rd_chk("mag224", 2'b00, 8'd224, 32'd673);
    rd_chk("ph100", 2'b01, 8'd100, 32'd500);
    rd_chk("reserved", 2'b11, 8'd4, 32'h0);

    mp(1'b1, 8'd0, 32'h999, 1'b0, 8'd0, 32'h0);
    rd_chk("st_idle_err", 2'b10, 8'd0, 32'h003F_E1E1);
    rd_chk("mag0", 2'b00, 8'd0, 32'd1);

    // reset in the middle of CLEAR
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    repeat (5) tick();
    reset = 1'b1;
    start = 1'b0;
    tick();
    reset = 1'b0;
    outs_zero("rst_clear");
    rd_chk("st_reset", 2'b10, 8'd0, 32'h0);
    mp(1'b1, 8'd1, 32'h42, 1'b0, 8'd0, 32'h0);
    rd_chk("st_idle", 2'b10, 8'd0, 32'h0008_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
